control_fsm: RTL and testbench

Multi-cycle control unit for the 32-bit cs147sec05 processor. It sits directly upstream of the data path: it drives the data path's 32-bit `CTRL` word plus the memory `READ`/`WRITE` strobes, and consumes the data path's `INSTRUCTION` and `ZERO` outputs. Every instruction takes five states: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK.

---
 rtl/control_fsm_pkg.sv | 91 +++++++++
 rtl/control_fsm_ctrl_decode.sv | 151 +++++++++++++++
 rtl/control_fsm.sv | 68 ++++++
 tb/tb_control_fsm.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/control_fsm_pkg.sv
// cs147 project definitions shared by the control unit: widths, opcodes, functs,
// ALU operation codes, CTRL bit indices and the control state encoding.
package control_fsm_pkg;

  localparam int unsigned CTRL_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JMP   = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_PUSH  = 6'h1b;
  localparam logic [5:0] OP_POP   = 6'h1c;
  localparam logic [5:0] OP_MULI  = 6'h1d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_MUL = 6'h2c;

  localparam logic [5:0] ALU_NONE = 6'd0;
  localparam logic [5:0] ALU_ADD  = 6'd1;
  localparam logic [5:0] ALU_SUB  = 6'd2;
  localparam logic [5:0] ALU_MUL  = 6'd3;
  localparam logic [5:0] ALU_SHR  = 6'd4;
  localparam logic [5:0] ALU_SHL  = 6'd5;
  localparam logic [5:0] ALU_AND  = 6'd6;
  localparam logic [5:0] ALU_OR   = 6'd7;
  localparam logic [5:0] ALU_NOR  = 6'd8;
  localparam logic [5:0] ALU_SLT  = 6'd9;

  localparam int unsigned B_PC_LOAD   = 0;
  localparam int unsigned B_PC_SEL_1  = 1;
  localparam int unsigned B_PC_SEL_2  = 2;
  localparam int unsigned B_PC_SEL_3  = 3;
  localparam int unsigned B_IR_LOAD   = 4;
  localparam int unsigned B_R1_SEL_1  = 5;
  localparam int unsigned B_REG_READ  = 6;
  localparam int unsigned B_REG_WRITE = 7;
  localparam int unsigned B_SP_LOAD   = 8;
  localparam int unsigned B_OP1_SEL   = 9;
  localparam int unsigned B_OP2_SEL_1 = 10;
  localparam int unsigned B_OP2_SEL_2 = 11;
  localparam int unsigned B_OP2_SEL_3 = 12;
  localparam int unsigned B_OP2_SEL_4 = 13;
  localparam int unsigned B_ALU_LO    = 14;
  localparam int unsigned B_ALU_HI    = 19;
  localparam int unsigned B_MA_SEL_1  = 20;
  localparam int unsigned B_MA_SEL_2  = 21;
  localparam int unsigned B_MD_SEL    = 22;
  localparam int unsigned B_WD_SEL_1  = 23;
  localparam int unsigned B_WD_SEL_2  = 24;
  localparam int unsigned B_WD_SEL_3  = 25;
  localparam int unsigned B_WA_SEL_1  = 26;
  localparam int unsigned B_WA_SEL_2  = 27;
  localparam int unsigned B_WA_SEL_3  = 28;

  function automatic state_t next_state(input state_t s);
    case (s)
      ST_FETCH:   return ST_DECODE;
      ST_DECODE:  return ST_EXECUTE;
      ST_EXECUTE: return ST_MEMORY;
      ST_MEMORY:  return ST_WRITEBACK;
      default:    return ST_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/control_fsm_ctrl_decode.sv
// Combinational CTRL/READ/WRITE generator for the state being entered.
// Stack instructions (push/pop) are decoded only when CTRL_STACK_OPS_EN is defined.
module ctrl_decode
  import control_fsm_pkg::*;
(
  input  state_t                state,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  zero,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic                  read,
  output logic                  write
);

`ifdef CTRL_STACK_OPS_EN
  localparam logic STACK_EN = 1'b1;
`else
  localparam logic STACK_EN = 1'b0;
`endif

  logic                  is_push;
  logic                  is_pop;
  logic                  r_alu;
  logic                  op1_sp;
  logic                  op2_shamt;
  logic                  op2_simm;
  logic                  op2_one;
  logic                  op2_r2;
  logic [5:0]            oprn;
  logic [CTRL_WIDTH-1:0] op_fields;
  logic [CTRL_WIDTH-1:0] wb_fields;

  always_comb begin
    is_push   = STACK_EN && (opcode == OP_PUSH);
    is_pop    = STACK_EN && (opcode == OP_POP);
    r_alu     = 1'b0;
    op1_sp    = 1'b0;
    op2_shamt = 1'b0;
    op2_simm  = 1'b0;
    op2_one   = 1'b0;
    op2_r2    = 1'b0;
    oprn      = ALU_NONE;

    case (opcode)
      OP_RTYPE: begin
        r_alu  = 1'b1;
        op2_r2 = 1'b1;
        case (funct)
          FN_ADD:  oprn = ALU_ADD;
          FN_SUB:  oprn = ALU_SUB;
          FN_MUL:  oprn = ALU_MUL;
          FN_AND:  oprn = ALU_AND;
          FN_OR:   oprn = ALU_OR;
          FN_NOR:  oprn = ALU_NOR;
          FN_SLT:  oprn = ALU_SLT;
          FN_SLL:  begin op2_r2 = 1'b0; op2_shamt = 1'b1; oprn = ALU_SHL; end
          FN_SRL:  begin op2_r2 = 1'b0; op2_shamt = 1'b1; oprn = ALU_SHR; end
          default: begin r_alu = 1'b0; op2_r2 = 1'b0; end
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin op2_simm = 1'b1; oprn = ALU_ADD; end
      OP_MULI:               begin op2_simm = 1'b1; oprn = ALU_MUL; end
      OP_SLTI:               begin op2_simm = 1'b1; oprn = ALU_SLT; end
      OP_ANDI:               oprn = ALU_AND;
      OP_ORI:                oprn = ALU_OR;
      OP_BEQ, OP_BNE:        begin op2_r2 = 1'b1; oprn = ALU_SUB; end
      OP_PUSH: if (is_push) begin op1_sp = 1'b1; op2_one = 1'b1; oprn = ALU_SUB; end
      OP_POP:  if (is_pop)  begin op1_sp = 1'b1; op2_one = 1'b1; oprn = ALU_ADD; end
      default: ;
    endcase

    // Operand/ALU fields are driven from EXECUTE and held through WRITEBACK
    op_fields                     = '0;
    op_fields[B_OP1_SEL]          = op1_sp;
    op_fields[B_OP2_SEL_1]        = op2_shamt;
    op_fields[B_OP2_SEL_2]        = op2_simm;
    op_fields[B_OP2_SEL_3]        = op2_shamt | op2_one;
    op_fields[B_OP2_SEL_4]        = op2_r2;
    op_fields[B_ALU_HI:B_ALU_LO]  = oprn;
  end

  always_comb begin
    wb_fields             = '0;
    wb_fields[B_PC_LOAD]  = 1'b1;
    wb_fields[B_PC_SEL_1] = 1'b1;
    wb_fields[B_PC_SEL_3] = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        if (r_alu) begin
          wb_fields[B_REG_WRITE] = 1'b1;
          wb_fields[B_WA_SEL_3]  = 1'b1;
          wb_fields[B_WD_SEL_3]  = 1'b1;
        end else if (funct == FN_JR) begin
          wb_fields[B_PC_SEL_1] = 1'b0;
        end
      end
      OP_ADDI, OP_MULI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
        wb_fields[B_REG_WRITE] = 1'b1;
        wb_fields[B_WA_SEL_1]  = 1'b1;
        wb_fields[B_WA_SEL_3]  = 1'b1;
        wb_fields[B_WD_SEL_3]  = 1'b1;
        wb_fields[B_WD_SEL_2]  = (opcode == OP_LUI);
        wb_fields[B_WD_SEL_1]  = (opcode == OP_LW);
      end
      OP_BEQ: wb_fields[B_PC_SEL_2] = zero;
      OP_BNE: wb_fields[B_PC_SEL_2] = ~zero;
      OP_JMP: wb_fields[B_PC_SEL_3] = 1'b0;
      OP_JAL: begin
        wb_fields[B_PC_SEL_3]  = 1'b0;
        wb_fields[B_REG_WRITE] = 1'b1;
        wb_fields[B_WA_SEL_2]  = 1'b1;
      end
      OP_PUSH: wb_fields[B_SP_LOAD] = is_push;
      OP_POP: begin
        wb_fields[B_SP_LOAD]   = is_pop;
        wb_fields[B_REG_WRITE] = is_pop;
        wb_fields[B_WD_SEL_3]  = is_pop;
        wb_fields[B_WD_SEL_1]  = is_pop;
      end
      default: ;
    endcase
  end

  always_comb begin
    ctrl  = '0;
    read  = 1'b0;
    write = 1'b0;
    case (state)
      ST_FETCH: begin
        ctrl[B_MA_SEL_2] = 1'b1;
        ctrl[B_IR_LOAD]  = 1'b1;
        read             = 1'b1;
      end
      ST_DECODE: begin
        ctrl[B_REG_READ] = 1'b1;
        ctrl[B_R1_SEL_1] = is_push;
      end
      ST_EXECUTE: ctrl = op_fields;
      ST_MEMORY: begin
        ctrl             = op_fields;
        ctrl[B_MA_SEL_1] = is_push;
        ctrl[B_MD_SEL]   = is_push;
        read             = (opcode == OP_LW) | is_pop;
        write            = (opcode == OP_SW) | is_push;
      end
      ST_WRITEBACK: ctrl = op_fields | wb_fields;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Five-state multi-cycle control unit for the cs147sec05 processor with registered
// Moore outputs. Optional stack instructions are enabled by CTRL_STACK_OPS_EN.
module control_fsm
  import control_fsm_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] INSTRUCTION,
  input  logic                  ZERO,
  output logic [CTRL_WIDTH-1:0] CTRL,
  output logic                  READ,
  output logic                  WRITE
);

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] ir;
  logic                  zero_q;
  logic [5:0]            opcode_src;
  logic [5:0]            funct_src;
  logic [CTRL_WIDTH-1:0] ctrl_nxt;
  logic                  read_nxt;
  logic                  write_nxt;
  logic                  unused_fields;

  assign unused_fields = ^{ir[25:6], INSTRUCTION[25:6]};

  always_comb begin
    state_nxt = next_state(state);
    // DECODE outputs are formed on the edge that loads ir, so look through to the bus
    if (state == ST_FETCH) begin
      opcode_src = INSTRUCTION[31:26];
      funct_src  = INSTRUCTION[5:0];
    end else begin
      opcode_src = ir[31:26];
      funct_src  = ir[5:0];
    end
  end

  ctrl_decode u_decode (
    .state  (state_nxt),
    .opcode (opcode_src),
    .funct  (funct_src),
    .zero   (zero_q),
    .ctrl   (ctrl_nxt),
    .read   (read_nxt),
    .write  (write_nxt)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_INIT;
      ir     <= '0;
      zero_q <= 1'b0;
      CTRL   <= '0;
      READ   <= 1'b0;
      WRITE  <= 1'b0;
    end else begin
      state <= state_nxt;
      CTRL  <= ctrl_nxt;
      READ  <= read_nxt;
      WRITE <= write_nxt;
      if (state == ST_FETCH)   ir     <= INSTRUCTION;
      if (state == ST_EXECUTE) zero_q <= ZERO;
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Randomized self-checking bench for control_fsm against a per-instruction behavioural model.
module tb_control_fsm;

`ifdef CTRL_STACK_OPS_EN
  localparam bit STACK = 1'b1;
`else
  localparam bit STACK = 1'b0;
`endif

  localparam logic [31:0] W_RD      = 32'h1200_0080;
  localparam logic [31:0] W_RT      = 32'h1600_0080;
  localparam logic [31:0] OP2_R2    = 32'h0000_2000;
  localparam logic [31:0] OP2_SIMM  = 32'h0000_0800;
  localparam logic [31:0] OP2_SHAMT = 32'h0000_1400;
  localparam logic [31:0] SP_ONE    = 32'h0000_1200;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        zero;
  logic [31:0] ctrl;
  logic        read;
  logic        write;

  int          checks = 0;
  int          errors = 0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_ctrl;
  logic        exp_read;
  logic        exp_write;
  string       exp_name = "";

  always #5 clk = ~clk;

  control_fsm dut (
    .CLK         (clk),
    .RST         (rst),
    .INSTRUCTION (instruction),
    .ZERO        (zero),
    .CTRL        (ctrl),
    .READ        (read),
    .WRITE       (write)
  );

  // Expected {WRITE, READ, CTRL} for an instruction in phase 0..4 (FETCH..WRITEBACK)
  function automatic logic [33:0] model(input logic [31:0] instr, input logic z, input int phase);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] ex;
    logic [31:0] mem_extra;
    logic [31:0] wb;
    logic        rd;
    logic        wr;
    int          oprn;
    op = instr[31:26];
    fn = instr[5:0];
    ex = 0; mem_extra = 0; wb = 32'h0000_000B; rd = 0; wr = 0; oprn = 0;
    case (op)
      6'h00: begin
        case (fn)
          6'h20: oprn = 1;
          6'h22: oprn = 2;
          6'h2c: oprn = 3;
          6'h24: oprn = 6;
          6'h25: oprn = 7;
          6'h27: oprn = 8;
          6'h2a: oprn = 9;
          6'h01: oprn = 5;
          6'h02: oprn = 4;
          default: oprn = 0;
        endcase
        if (fn == 6'h01 || fn == 6'h02) ex = OP2_SHAMT;
        else if (oprn != 0) ex = OP2_R2;
        if (oprn != 0) wb |= W_RD;
        if (fn == 6'h08) wb &= ~32'h2;
      end
      6'h08: begin oprn = 1; ex = OP2_SIMM; wb |= W_RT; end
      6'h1d: begin oprn = 3; ex = OP2_SIMM; wb |= W_RT; end
      6'h0a: begin oprn = 9; ex = OP2_SIMM; wb |= W_RT; end
      6'h0c: begin oprn = 6; wb |= W_RT; end
      6'h0d: begin oprn = 7; wb |= W_RT; end
      6'h0f: wb |= W_RT | 32'h0100_0000;
      6'h23: begin oprn = 1; ex = OP2_SIMM; rd = 1; wb |= W_RT | 32'h0080_0000; end
      6'h2b: begin oprn = 1; ex = OP2_SIMM; wr = 1; end
      6'h04: begin oprn = 2; ex = OP2_R2; if (z) wb |= 32'h4; end
      6'h05: begin oprn = 2; ex = OP2_R2; if (!z) wb |= 32'h4; end
      6'h02: wb &= ~32'h8;
      6'h03: wb = (wb & ~32'h8) | 32'h0800_0080;
      6'h1b: if (STACK) begin
        oprn = 2; ex = SP_ONE; wr = 1; mem_extra = 32'h0050_0000; wb |= 32'h100;
      end
      6'h1c: if (STACK) begin
        oprn = 1; ex = SP_ONE; rd = 1; wb |= 32'h0280_0180;
      end
      default: ;
    endcase
    ex |= 32'(oprn) << 14;
    case (phase)
      0:       return {2'b01, 32'h0020_0010};
      1:       return {2'b00, 32'h40 | ((STACK && op == 6'h1b) ? 32'h20 : 32'h0)};
      2:       return {2'b00, ex};
      3:       return {wr, rd, ex | mem_extra};
      default: return {2'b00, ex | wb};
    endcase
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (ctrl !== exp_ctrl || read !== exp_read || write !== exp_write) begin
        errors++;
        $display("FAIL %s: CTRL=%08h READ=%b WRITE=%b, expected CTRL=%08h READ=%b WRITE=%b",
                 exp_name, ctrl, read, write, exp_ctrl, exp_read, exp_write);
      end
      checks++;
      if (read === 1'b1 && write === 1'b1) begin
        errors++;
        $display("FAIL %s_strobes: READ=%b WRITE=%b, expected not both 1", exp_name, read, write);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_vec(input logic [33:0] v, input string name);
    exp_write = v[33];
    exp_read  = v[32];
    exp_ctrl  = v[31:0];
    exp_name  = name;
    exp_valid = 1'b1;
  endtask

  task automatic pin(input string name, input logic [33:0] got, input logic [33:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL pin_%s: model=%09h, expected %09h", name, got, want);
    end
  endtask

  task automatic run_instr(input logic [31:0] word, input logic z, input int abort_at);
    for (int unsigned ph = 0; ph < 5; ph++) begin
      step();
      expect_vec(model(word, z, int'(ph)), $sformatf("ph%0d_w%08h_z%0b", ph, word, z));
      case (ph)
        0: instruction = word;
        1: instruction = $urandom;
        2: zero = z;
        3: zero = 1'($urandom);
        default: ;
      endcase
      if (int'(ph) == abort_at) begin
        rst = 1'b1;
        step();
        expect_vec('0, $sformatf("abort_ph%0d_w%08h", ph, word));
        rst = 1'b0;
        return;
      end
    end
  endtask

  function automatic logic [5:0] pick_funct();
    case ($urandom_range(0, 10))
      0: return 6'h20;
      1: return 6'h22;
      2: return 6'h2c;
      3: return 6'h24;
      4: return 6'h25;
      5: return 6'h27;
      6: return 6'h2a;
      7: return 6'h01;
      8: return 6'h02;
      9: return 6'h08;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 17))
      0, 1, 2: begin w[31:26] = 6'h00; w[5:0] = pick_funct(); end
      3:  w[31:26] = 6'h08;
      4:  w[31:26] = 6'h1d;
      5:  w[31:26] = 6'h0a;
      6:  w[31:26] = 6'h0c;
      7:  w[31:26] = 6'h0d;
      8:  w[31:26] = 6'h0f;
      9:  w[31:26] = 6'h23;
      10: w[31:26] = 6'h2b;
      11: w[31:26] = 6'h04;
      12: w[31:26] = 6'h05;
      13: w[31:26] = 6'h02;
      14: w[31:26] = 6'h03;
      15: w[31:26] = 6'h1b;
      16: w[31:26] = 6'h1c;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    rst = 1'b1;
    instruction = '0;
    zero = 1'b0;

    pin("fetch",     model(32'h0022_1820, 1'b0, 0), {2'b01, 32'h0020_0010});
    pin("add_ex",    model(32'h0022_1820, 1'b0, 2), {2'b00, 32'h0000_6000});
    pin("add_wb",    model(32'h0022_1820, 1'b0, 4), {2'b00, 32'h1200_608B});
    pin("beq_wb_z1", model(32'h1022_0004, 1'b1, 4), {2'b00, 32'h0000_A00F});
    pin("beq_wb_z0", model(32'h1022_0004, 1'b0, 4), {2'b00, 32'h0000_A00B});
    pin("jal_wb",    model(32'h0C00_0100, 1'b0, 4), {2'b00, 32'h0800_0083});
    pin("sw_mem",    model(32'hAC22_0004, 1'b0, 3), {2'b10, 32'h0000_4800});
    pin("ill_mem",   model(32'hFC00_0000, 1'b0, 3), {2'b00, 32'h0000_0000});
    pin("ill_wb",    model(32'hFC00_0000, 1'b0, 4), {2'b00, 32'h0000_000B});
`ifdef CTRL_STACK_OPS_EN
    pin("push_ex",   model(32'h6C00_0000, 1'b0, 2), {2'b00, 32'h0000_9200});
    pin("push_mem",  model(32'h6C00_0000, 1'b0, 3), {2'b10, 32'h0050_9200});
    pin("push_wb",   model(32'h6C00_0000, 1'b0, 4), {2'b00, 32'h0000_930B});
`else
    pin("push_mem",  model(32'h6C00_0000, 1'b0, 3), {2'b00, 32'h0000_0000});
    pin("push_wb",   model(32'h6C00_0000, 1'b0, 4), {2'b00, 32'h0000_000B});
`endif

    step();
    expect_vec('0, "reset");
    step();
    expect_vec('0, "reset_hold");
    rst = 1'b0;

    run_instr(32'hAC22_0004, 1'b0, 2);
    run_instr(32'h0022_1820, 1'b0, -1);
    run_instr(32'h1022_0004, 1'b1, -1);
    run_instr(32'h1022_0004, 1'b0, -1);
    run_instr(32'h1422_0004, 1'b0, -1);
    run_instr(32'h0C00_0100, 1'b0, -1);
    run_instr(32'h6C00_0000, 1'b0, -1);
    run_instr(32'h7000_0000, 1'b0, -1);
    run_instr(32'hFC00_0000, 1'b0, -1);
    run_instr(32'h03E0_0008, 1'b0, -1);
    run_instr(32'h6C00_0000, 1'b0, 3);

    for (int unsigned n = 0; n < 400; n++) begin
      int abort_at;
      abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(rand_instr(), 1'($urandom), abort_at);
    end

    @(negedge clk);
    #1;
    exp_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
